// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

   localparam int unsigned PC_W_DEF = 32;
   localparam int unsigned STALL_W  = 6;

   // Hold masks: bit0 PC, bit1 IF2ID, bit2 ID2EX, bit3 EX2MEM, bit4 MEM2WB, bit5 WB
   localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
   localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
   localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
   localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
   localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_PEND  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   // Deepest requesting stage wins; it and everything upstream is held
   function automatic logic [STALL_W-1:0] stall_prio(
      input logic if_req,
      input logic id_req,
      input logic ex_req,
      input logic mem_req
   );
      logic [STALL_W-1:0] m;
      m = STALL_NONE;
      if (mem_req)     m = STALL_MEM;
      else if (ex_req) m = STALL_EX;
      else if (id_req) m = STALL_ID;
      else if (if_req) m = STALL_IF;
      return m;
   endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);

   // Count enabled cycles, holding at all-ones once reached
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt_o <= '0;
      end else if (en_i && (cnt_o != '1)) begin
         cnt_o <= cnt_o + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: priority stalls, exception redirect, event counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned PC_W  = PC_W_DEF,
   parameter int unsigned CNT_W = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               if_stallreq_i,
   input  logic               id_stallreq_i,
   input  logic               ex_stallreq_i,
   input  logic               mem_stallreq_i,
   input  logic               excp_i,
   input  logic [PC_W-1:0]    excp_target_i,
   output logic [STALL_W-1:0] stall_o,
   output logic               flush_o,
   output logic [PC_W-1:0]    new_pc_o,
   output logic [CNT_W-1:0]   stall_cnt_o,
   output logic [15:0]        flush_cnt_o
);

   state_e             state_q, state_d;
   logic [PC_W-1:0]    tgt_q, tgt_d;
   logic [STALL_W-1:0] stall_d;

   // State and redirect-target registers
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= ST_RUN;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

   // Next-state, target capture and stall mask
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      stall_d = STALL_NONE;
      unique case (state_q)
         ST_RUN: begin
            stall_d = stall_prio(if_stallreq_i, id_stallreq_i, ex_stallreq_i, mem_stallreq_i);
            if (excp_i) begin
               tgt_d = excp_target_i;
               if (mem_stallreq_i) begin
                  state_d = ST_PEND;
               end else begin
                  stall_d = STALL_ALL;
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_PEND: begin
            stall_d = STALL_ALL;
            if (!mem_stallreq_i) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Outputs are forced quiet while reset is asserted, including a reset landing in FLUSH
   always_comb begin
      stall_o  = rst_i ? stall_d : STALL_NONE;
      flush_o  = rst_i && (state_q == ST_FLUSH);
      new_pc_o = flush_o ? tgt_q : '0;
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (|stall_o),
      .cnt_o (stall_cnt_o)
   );

   sat_counter #(
      .WIDTH (16)
   ) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (flush_o),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic against a reference model.
module tb_pipe_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_stallreq_i, id_stallreq_i, ex_stallreq_i, mem_stallreq_i;
   logic        excp_i;
   logic [31:0] excp_target_i;

   logic [5:0]  stall_o, stall_s;
   logic        flush_o, flush_s;
   logic [31:0] new_pc_o, new_pc_s;
   logic [31:0] stall_cnt_o;
   logic [3:0]  stall_cnt_s;
   logic [15:0] flush_cnt_o, flush_cnt_s;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   // Reference model: redirect bookkeeping and counters in plain integers
   bit          m_waiting;   // exception accepted, waiting for memory to drain
   bit          m_flush_now; // this cycle is the flush pulse
   logic [31:0] m_tgt;
   longint      m_scnt;
   longint      m_fcnt;

   always #5 clk_i = ~clk_i;

   pipe_ctrl #(.PC_W(32), .CNT_W(32)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .if_stallreq_i  (if_stallreq_i),
      .id_stallreq_i  (id_stallreq_i),
      .ex_stallreq_i  (ex_stallreq_i),
      .mem_stallreq_i (mem_stallreq_i),
      .excp_i         (excp_i),
      .excp_target_i  (excp_target_i),
      .stall_o        (stall_o),
      .flush_o        (flush_o),
      .new_pc_o       (new_pc_o),
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
   );

   pipe_ctrl #(.PC_W(32), .CNT_W(4)) dut_small (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .if_stallreq_i  (if_stallreq_i),
      .id_stallreq_i  (id_stallreq_i),
      .ex_stallreq_i  (ex_stallreq_i),
      .mem_stallreq_i (mem_stallreq_i),
      .excp_i         (excp_i),
      .excp_target_i  (excp_target_i),
      .stall_o        (stall_s),
      .flush_o        (flush_s),
      .new_pc_o       (new_pc_s),
      .stall_cnt_o    (stall_cnt_s),
      .flush_cnt_o    (flush_cnt_s)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Number of held registers = index of deepest requesting stage + 2
   function automatic logic [5:0] prio_mask(input logic f, input logic d, input logic e, input logic m);
      int n;
      n = m ? 5 : e ? 4 : d ? 3 : f ? 2 : 0;
      return 6'((1 << n) - 1);
   endfunction

   // One clock: check outputs mid-cycle, then advance the model at the edge
   task automatic step();
      logic [5:0]  e_stall;
      logic        e_flush;
      logic [31:0] e_pc;
      @(negedge clk_i);
      e_stall = '0;
      e_flush = 1'b0;
      e_pc    = '0;
      if (rst_i) begin
         if (m_flush_now) begin
            e_flush = 1'b1;
            e_pc    = m_tgt;
         end else if (m_waiting) begin
            e_stall = '1;
         end else if (excp_i && !mem_stallreq_i) begin
            e_stall = '1;
         end else begin
            e_stall = prio_mask(if_stallreq_i, id_stallreq_i, ex_stallreq_i, mem_stallreq_i);
         end
      end
      check("stall",      64'(stall_o),     64'(e_stall));
      check("flush",      64'(flush_o),     64'(e_flush));
      check("new_pc",     64'(new_pc_o),    64'(e_pc));
      check("stall_cnt",  64'(stall_cnt_o), 64'((m_scnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_scnt));
      check("flush_cnt",  64'(flush_cnt_o), 64'((m_fcnt > 65535) ? 65535 : m_fcnt));
      check("stall_cnt4", 64'(stall_cnt_s), 64'((m_scnt > 15) ? 15 : m_scnt));
      @(posedge clk_i);
      if (!rst_i) begin
         m_waiting = 0; m_flush_now = 0; m_tgt = '0; m_scnt = 0; m_fcnt = 0;
      end else begin
         if (e_stall != 0) m_scnt++;
         if (m_flush_now) begin
            m_fcnt++;
            m_flush_now = 0;
         end else if (m_waiting) begin
            if (!mem_stallreq_i) begin
               m_waiting   = 0;
               m_flush_now = 1;
            end
         end else if (excp_i) begin
            m_tgt = excp_target_i;
            if (mem_stallreq_i) m_waiting = 1;
            else                m_flush_now = 1;
         end
      end
      #1;
   endtask

   task automatic idle();
      if_stallreq_i = 0; id_stallreq_i = 0; ex_stallreq_i = 0; mem_stallreq_i = 0;
      excp_i = 0; excp_target_i = '0;
   endtask

   initial begin
      logic [31:0] base;
      m_waiting = 0; m_flush_now = 0; m_tgt = '0; m_scnt = 0; m_fcnt = 0;
      rst_i = 0;
      idle();
      // Reset with requests active must still keep outputs quiet
      id_stallreq_i = 1; excp_i = 1; excp_target_i = 32'h1234_5678;
      step(); step();
      idle();
      rst_i = 1;
      step();

      // Decode and execute requests together hold through ID2EX/EX2MEM
      base = stall_cnt_o;
      id_stallreq_i = 1; ex_stallreq_i = 1;
      repeat (3) step();
      check("stall_cnt_plus3", 64'(stall_cnt_o - base), 64'd3);
      idle(); step();

      // Clean exception: full stall, then single flush pulse
      excp_i = 1; excp_target_i = 32'hBFC0_0380;
      step();
      idle();
      step();
      check("flush_cnt_one", 64'(flush_cnt_o), 64'd1);
      step();

      // Exception during a memory stall waits in PEND for five cycles
      excp_i = 1; excp_target_i = 32'hA000_0010; mem_stallreq_i = 1;
      step();
      excp_i = 0;
      repeat (4) step();
      mem_stallreq_i = 0;
      step(); step(); step();

      // Second exception while pending is ignored
      excp_i = 1; excp_target_i = 32'h8000_0180; mem_stallreq_i = 1;
      step();
      excp_target_i = 32'h8000_0000;
      step();
      excp_i = 0; mem_stallreq_i = 0;
      step(); step(); step();

      // Reset in PEND discards the redirect
      base = flush_cnt_o;
      excp_i = 1; excp_target_i = 32'hDEAD_BEE0; mem_stallreq_i = 1;
      step();
      excp_i = 0; rst_i = 0;
      step();
      rst_i = 1; mem_stallreq_i = 0;
      repeat (4) step();
      check("no_flush_after_rst", 64'(flush_cnt_o), 64'd0);

      // Narrow counter saturates
      if_stallreq_i = 1;
      repeat (20) step();
      check("stall_cnt4_sat", 64'(stall_cnt_s), 64'hF);
      idle(); step();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst_i          = ($urandom_range(0, 199) != 0);
         if_stallreq_i  = ($urandom_range(0, 3) == 0);
         id_stallreq_i  = ($urandom_range(0, 4) == 0);
         ex_stallreq_i  = ($urandom_range(0, 5) == 0);
         mem_stallreq_i = ($urandom_range(0, 2) == 0);
         excp_i         = ($urandom_range(0, 9) == 0);
         excp_target_i  = $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning redirect-address width.
REQ-002 SHALL have parameter CNT_W, default 32, meaning stall-cycle counter width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port if_stallreq_i, input, 1, fetch stage stall request (icache miss).
REQ-006 SHALL have port id_stallreq_i, input, 1, decode stall request (load-use).
REQ-007 SHALL have port ex_stallreq_i, input, 1, execute stall request (multi-cycle mul/div).
REQ-008 SHALL have port mem_stallreq_i, input, 1, memory stall request (dcache busy).
REQ-009 SHALL have port excp_i, input, 1, exception/eret detected in MEM.
REQ-010 SHALL have port excp_target_i, input, PC_W, redirect address valid with excp_i.
REQ-011 SHALL have port stall_o, output, 6, per-register hold: bit0 PC, bit1 IF2ID, bit2 ID2EX, bit3 EX2MEM, bit4 MEM2WB, bit5 WB.
REQ-012 SHALL have port flush_o, output, 1, clear all pipeline registers to their reset bubble.
REQ-013 SHALL have port new_pc_o, output, PC_W, redirect address, valid when flush_o=1.
REQ-014 SHALL have port stall_cnt_o, output, CNT_W, count of cycles with any stall_o bit set.
REQ-015 SHALL have port flush_cnt_o, output, 16, count of flush pulses issued.

Function
REQ-016 SHALL implement FSM states RUN, PEND, FLUSH.
REQ-017 In RUN, stall_o SHALL be priority-encoded combinationally, highest stage wins: mem->6'b011111, ex->6'b001111, id->6'b000111, if->6'b000011, none->6'b000000.
REQ-018 RUN + excp_i=1 + mem_stallreq_i=0: latch excp_target_i, stall_o=6'b111111 that cycle, next state FLUSH.
REQ-019 RUN + excp_i=1 + mem_stallreq_i=1: latch excp_target_i, stall_o per REQ-017, next state PEND.
REQ-020 PEND: stall_o=6'b111111 while mem_stallreq_i=1; when mem_stallreq_i=0, stall_o=6'b111111 and next state FLUSH.
REQ-021 FLUSH: flush_o=1 and new_pc_o=latched target for exactly one cycle, stall_o=6'b000000, next state RUN regardless of requests.
REQ-022 flush_o and new_pc_o SHALL be registered (decoded from state/latch); latency excp_i accept -> flush_o = 1 cycle.
REQ-023 excp_i asserted in PEND or FLUSH SHALL be ignored; first latched target wins.
REQ-024 new_pc_o SHALL be 0 outside FLUSH.
REQ-025 stall_cnt_o SHALL increment by 1 per cycle with stall_o!=0 and saturate at all-ones.
REQ-026 flush_cnt_o SHALL increment on each FLUSH cycle and saturate at 16'hFFFF.
REQ-027 Requests in the FLUSH cycle SHALL not stall; they are re-evaluated in the next RUN cycle.

Reset
REQ-028 rst_i=0 at a clock edge SHALL force state RUN, latched target 0, stall_cnt_o 0, flush_cnt_o 0.
REQ-029 During reset stall_o=0, flush_o=0, new_pc_o=0; reset in PEND or FLUSH SHALL discard the pending redirect with no flush pulse.

Structure
REQ-030 Shared package SHALL hold the FSM state enum, stall vector width 6, named stall encodings, PC_W default.
REQ-031 One sub-module, sat_counter (parameterised width, enable, sync active-low clear), SHALL be instantiated for both counters.

Verification
REQ-032 id_stallreq_i=1 and ex_stallreq_i=1 together for 3 cycles -> stall_o=6'b001111 each cycle, stall_cnt_o +3.
REQ-033 excp_i=1, target 32'hBFC00380, no stalls at cycle N -> stall_o=6'b111111 at N; flush_o=1, new_pc_o=32'hBFC00380 at N+1 only; flush_cnt_o=1.
REQ-034 excp_i at N with mem_stallreq_i=1 for cycles N..N+4 -> stall_o=6'b011111 at N, 6'b111111 at N+1..N+5, flush_o=1 at N+6.
REQ-035 Second excp_i (target 32'h80000000) during PEND -> flush carries first target only; one flush pulse.
REQ-036 rst_i=0 in the PEND state -> no flush_o ever; all outputs 0 next cycle.
REQ-037 Preload stall_cnt_o near all-ones via CNT_W=4, 20 stalled cycles -> stall_cnt_o holds 4'hF.
